// File: rtl/sequence_capture.sv
// Captures a sequence of single-switch presses into packed 2-bit codes,
// with per-press/release inactivity timeout and one-cycle status pulses.
module sequence_capture #(
  parameter int MAX_LEN      = 16,
  parameter int TIMEOUT_CLKS = 75000000
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Switch_1,
  input  logic                   i_Switch_2,
  input  logic                   i_Switch_3,
  input  logic                   i_Switch_4,
  input  logic                   i_Start,
  input  logic [4:0]             i_Len,
  output logic [2*MAX_LEN-1:0]   o_Seq,
  output logic [4:0]             o_Count,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic                   o_Error,
  output logic                   o_Timeout
);

  localparam int TMO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);
  localparam logic [5:0] MAX_LEN_W = 6'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    DONE,
    ERROR
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             sw, sw_p1;
  logic [1:0]             code_q, code_d;
  logic [4:0]             len_q;
  logic [4:0]             count_q;
  logic [2*MAX_LEN-1:0]   seq_q;
  logic [TMO_W-1:0]       tmo_q;
  logic                   tmo_flag_q;
  logic                   press, one_hot, len_ok, tmo_expired;
  logic                   accept, commit, timeout_hit;

  function automatic logic [1:0] sw_code(input logic [3:0] s);
    logic [1:0] c;
    c = 2'd0;
    unique case (s)
      4'b0010: c = 2'd1;
      4'b0100: c = 2'd2;
      4'b1000: c = 2'd3;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

  assign sw          = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};
  // A press is an edge from all-released, so switches held on entry never count.
  assign press       = (sw_p1 == 4'b0000) && (sw != 4'b0000);
  assign one_hot     = (sw == 4'b0001) || (sw == 4'b0010) ||
                       (sw == 4'b0100) || (sw == 4'b1000);
  assign len_ok      = (i_Len != 5'd0) && ({1'b0, i_Len} <= MAX_LEN_W);
  assign tmo_expired = (tmo_q == TMO_LAST);

  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    accept      = 1'b0;
    commit      = 1'b0;
    timeout_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_Start) begin
          if (len_ok) begin
            accept  = 1'b1;
            state_d = WAIT_PRESS;
          end else begin
            state_d = ERROR;
          end
        end
      end
      WAIT_PRESS: begin
        if (press) begin
          if (one_hot) begin
            code_d  = sw_code(sw);
            state_d = WAIT_RELEASE;
          end else begin
            state_d = ERROR;
          end
        end else if (tmo_expired) begin
          timeout_hit = 1'b1;
          state_d     = ERROR;
        end
      end
      WAIT_RELEASE: begin
        if ((sw & ~(4'b0001 << code_q)) != 4'b0000) begin
          state_d = ERROR;
        end else if (sw == 4'b0000) begin
          commit  = 1'b1;
          state_d = ((count_q + 5'd1) == len_q) ? DONE : WAIT_PRESS;
        end else if (tmo_expired) begin
          timeout_hit = 1'b1;
          state_d     = ERROR;
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q    <= IDLE;
      sw_p1      <= 4'b0000;
      code_q     <= 2'd0;
      len_q      <= 5'd0;
      count_q    <= 5'd0;
      seq_q      <= '0;
      tmo_q      <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sw_p1      <= sw;
      code_q     <= code_d;
      tmo_flag_q <= timeout_hit;
      if (state_d != state_q) begin
        tmo_q <= '0;
      end else if (state_q == WAIT_PRESS || state_q == WAIT_RELEASE) begin
        tmo_q <= tmo_q + 1'b1;
      end else begin
        tmo_q <= '0;
      end
      if (accept) begin
        len_q   <= i_Len;
        count_q <= 5'd0;
        seq_q   <= '0;
      end else if (commit) begin
        count_q <= count_q + 5'd1;
        for (int k = 0; k < MAX_LEN; k++) begin
          if (count_q == 5'(k)) begin
            seq_q[2*k +: 2] <= code_q;
          end
        end
      end
    end
  end

  assign o_Seq     = seq_q;
  assign o_Count   = count_q;
  assign o_Busy    = (state_q == WAIT_PRESS) || (state_q == WAIT_RELEASE);
  assign o_Done    = (state_q == DONE);
  assign o_Error   = (state_q == ERROR);
  assign o_Timeout = (state_q == ERROR) && tmo_flag_q;

endmodule

// File: tb/tb_sequence_capture.sv
// Directed, table-driven bench for sequence_capture (MAX_LEN=16, TIMEOUT_CLKS=100).
module tb_sequence_capture;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 100;

  logic                 clk;
  logic                 rst_n;
  logic [3:0]           sw;
  logic                 start;
  logic [4:0]           len;
  logic [2*MAX_LEN-1:0] seq;
  logic [4:0]           count;
  logic                 busy, done, err, tmo;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0, err_cnt = 0, tmo_cnt = 0, busy_cnt = 0;

  sequence_capture #(.MAX_LEN(MAX_LEN), .TIMEOUT_CLKS(TMO)) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Switch_1 (sw[0]),
    .i_Switch_2 (sw[1]),
    .i_Switch_3 (sw[2]),
    .i_Switch_4 (sw[3]),
    .i_Start    (start),
    .i_Len      (len),
    .o_Seq      (seq),
    .o_Count    (count),
    .o_Busy     (busy),
    .o_Done     (done),
    .o_Error    (err),
    .o_Timeout  (tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse/level counters sampled shortly after each active edge.
  always @(posedge clk) begin
    #1;
    if (done) done_cnt++;
    if (err)  err_cnt++;
    if (tmo)  tmo_cnt++;
    if (busy) busy_cnt++;
  end

  typedef struct {
    logic [4:0]  len;
    int          npress;
    logic [15:0] press;
    logic        exp_done;
    logic        exp_err;
    logic [4:0]  exp_cnt;
    logic [7:0]  exp_seq;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic press_release(input logic [3:0] p);
    sw = p;
    repeat (3) @(negedge clk);
    sw = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_start(input logic [4:0] l);
    start = 1'b1;
    len   = l;
    @(negedge clk);
    start = 1'b0;
    len   = 5'd0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 20 && busy; i++) @(negedge clk);
    chk(name, {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int d0, e0, t0, b0;
    d0 = done_cnt; e0 = err_cnt; t0 = tmo_cnt; b0 = busy_cnt;
    do_start(v.len);
    for (int p = 0; p < v.npress; p++) press_release(v.press[4*p +: 4]);
    wait_idle($sformatf("v%0d_idle", idx));
    chk($sformatf("v%0d_done", idx), done_cnt - d0, {31'd0, v.exp_done});
    chk($sformatf("v%0d_err", idx), err_cnt - e0, {31'd0, v.exp_err});
    chk($sformatf("v%0d_tmo", idx), tmo_cnt - t0, 32'd0);
    chk($sformatf("v%0d_count", idx), {27'd0, count}, {27'd0, v.exp_cnt});
    chk($sformatf("v%0d_seq", idx), seq, {24'd0, v.exp_seq});
    chk($sformatf("v%0d_busy_seen", idx), {31'd0, (busy_cnt != b0)},
        {31'd0, (v.npress != 0)});
  endtask

  initial begin
    int d0, e0, t0, n;
    rst_n = 1'b0; sw = 4'b0000; start = 1'b0; len = 5'd0;

    vecs[0] = '{5'd3,  3, 16'h0182, 1'b1, 1'b0, 5'd3, 8'h0D};
    vecs[1] = '{5'd1,  1, 16'h0004, 1'b1, 1'b0, 5'd1, 8'h02};
    vecs[2] = '{5'd2,  2, 16'h0068, 1'b0, 1'b1, 5'd1, 8'h03};
    vecs[3] = '{5'd4,  4, 16'h1248, 1'b1, 1'b0, 5'd4, 8'h1B};
    vecs[4] = '{5'd0,  0, 16'h0000, 1'b0, 1'b1, 5'd4, 8'h1B};
    vecs[5] = '{5'd17, 0, 16'h0000, 1'b0, 1'b1, 5'd4, 8'h1B};

    repeat (3) @(negedge clk);
    chk("rst_seq", seq, 32'd0);
    chk("rst_flags", {27'd0, count, busy, done, err, tmo}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Full-length capture: press k uses switch k%4.
    d0 = done_cnt;
    do_start(5'd16);
    for (int k = 0; k < 16; k++) press_release(4'b0001 << (k % 4));
    wait_idle("len16_idle");
    chk("len16_done", done_cnt - d0, 32'd1);
    chk("len16_count", {27'd0, count}, 32'd16);
    chk("len16_seq", seq, 32'hE4E4E4E4);

    // Second switch while the first is still held.
    d0 = done_cnt; e0 = err_cnt; t0 = tmo_cnt;
    do_start(5'd2);
    sw = 4'b0001;
    repeat (3) @(negedge clk);
    sw = 4'b0101;
    repeat (2) @(negedge clk);
    sw = 4'b0000;
    wait_idle("overlap_idle");
    chk("overlap_err", err_cnt - e0, 32'd1);
    chk("overlap_tmo", tmo_cnt - t0, 32'd0);
    chk("overlap_done", done_cnt - d0, 32'd0);
    chk("overlap_count", {27'd0, count}, 32'd0);

    // Inactivity timeout after one committed press.
    e0 = err_cnt; t0 = tmo_cnt;
    do_start(5'd2);
    sw = 4'b0010;
    repeat (3) @(negedge clk);
    sw = 4'b0000;
    n = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (err) begin
        n = i;
        break;
      end
    end
    chk("tmo_latency", n, 32'd101);
    chk("tmo_flag", {31'd0, tmo}, 32'd1);
    chk("tmo_count", {27'd0, count}, 32'd1);
    chk("tmo_seq", seq, 32'h1);
    wait_idle("tmo_idle");
    chk("tmo_pulses", {err_cnt - e0, tmo_cnt - t0}, {32'd1, 32'd1});

    // Asynchronous reset in the middle of a capture.
    do_start(5'd4);
    press_release(4'b0001);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seq", seq, 32'd0);
    chk("arst_flags", {27'd0, count, busy, done, err, tmo}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    d0 = done_cnt;
    do_start(5'd1);
    press_release(4'b0100);
    wait_idle("arst_idle");
    chk("arst_done", done_cnt - d0, 32'd1);
    chk("arst_seq2", seq, 32'h2);

    // Switch already held when the capture is armed.
    d0 = done_cnt;
    sw = 4'b0010;
    repeat (2) @(negedge clk);
    do_start(5'd1);
    repeat (3) @(negedge clk);
    chk("held_busy", {31'd0, busy}, 32'd1);
    chk("held_count", {27'd0, count}, 32'd0);
    sw = 4'b0000;
    repeat (2) @(negedge clk);
    chk("held_count2", {27'd0, count}, 32'd0);
    press_release(4'b0010);
    wait_idle("held_idle");
    chk("held_done", done_cnt - d0, 32'd1);
    chk("held_count3", {27'd0, count}, 32'd1);
    chk("held_seq", seq, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
